// File: rtl/serial_link_port_if.sv
// Word-level handshake bundle between the CPU side and serial_link_port.
// The master modport is the CPU side; the port itself uses the slave modport.
interface serial_link_port_if #(
  parameter int WORD_BITS = 16
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [WORD_BITS-1:0] tx_data;
  logic                 tx_kind;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [WORD_BITS-1:0] rx_data;
  logic                 rx_overflow;

  modport master (
    output tx_valid, tx_data, tx_kind, rx_ready,
    input  tx_ready, rx_valid, rx_data, rx_overflow
  );

  modport slave (
    input  tx_valid, tx_data, tx_kind, rx_ready,
    output tx_ready, rx_valid, rx_data, rx_overflow
  );
endinterface

// File: rtl/serial_link_port.sv
// Framed serial port: the TX side serialises one word per frame onto IO_BITS pins
// (start cycle, then LSB-first beats), and the RX side synchronises, detects and
// deserialises frames into a single-entry valid/ready output slot.
module serial_link_port #(
  parameter int IO_BITS   = 2,
  parameter int WORD_BITS = 16,
  parameter int RX_SYNC   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_link_port_if.slave   bus,
  output logic [IO_BITS-1:0]  tx_pins,
  output logic                tx_fetch,
  output logic                tx_busy,
  input  logic [IO_BITS-1:0]  rx_pins,
  output logic                rx_busy
);

  localparam int BEATS  = WORD_BITS / IO_BITS;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [IO_BITS-1:0] START_PAT = IO_BITS'(1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_DATA
  } rx_state_t;

  // ---------------------------------------------------------------- TX side

  tx_state_t             tx_state, tx_state_d;
  logic [BEAT_W-1:0]     tx_beat, tx_beat_d;
  logic [WORD_BITS-1:0]  tx_word, tx_word_d;
  logic                  tx_kind_q, tx_kind_d;
  logic [IO_BITS-1:0]    tx_pins_q, tx_pins_d;
  logic                  tx_fetch_q, tx_fetch_d;
  logic                  tx_ready_c;
  logic                  tx_fire;

  // A new word is taken when idle or during the last beat, so frames can abut.
  assign tx_ready_c = (tx_state == TX_IDLE) ||
                      ((tx_state == TX_DATA) && (tx_beat == LAST_BEAT));
  assign tx_fire    = bus.tx_valid && tx_ready_c;

  // TX state register, beat counter and latched word/flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_beat   <= '0;
      tx_word   <= '0;
      tx_kind_q <= 1'b0;
    end else begin
      tx_state  <= tx_state_d;
      tx_beat   <= tx_beat_d;
      tx_word   <= tx_word_d;
      tx_kind_q <= tx_kind_d;
    end
  end

  // TX next-state: start cycle, then BEATS data cycles, optionally chaining a new frame.
  always_comb begin
    tx_state_d = tx_state;
    tx_beat_d  = tx_beat;
    case (tx_state)
      TX_IDLE: begin
        if (tx_fire) begin
          tx_state_d = TX_START;
        end
        tx_beat_d = '0;
      end
      TX_START: begin
        tx_state_d = TX_DATA;
        tx_beat_d  = '0;
      end
      TX_DATA: begin
        if (tx_beat == LAST_BEAT) begin
          tx_state_d = tx_fire ? TX_START : TX_IDLE;
          tx_beat_d  = '0;
        end else begin
          tx_beat_d = tx_beat + BEAT_W'(1);
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_beat_d  = '0;
      end
    endcase
  end

  // TX outputs: pin values for the coming cycle, derived from the next state so the pins can be registered.
  always_comb begin
    tx_word_d  = tx_word;
    tx_kind_d  = tx_kind_q;
    if (tx_fire) begin
      tx_word_d = bus.tx_data;
      tx_kind_d = bus.tx_kind;
    end
    tx_pins_d  = '0;
    tx_fetch_d = 1'b0;
    case (tx_state_d)
      TX_START: begin
        tx_pins_d  = START_PAT;
        tx_fetch_d = tx_kind_d;
      end
      TX_DATA: begin
        tx_pins_d  = tx_word_d[int'(tx_beat_d)*IO_BITS +: IO_BITS];
        tx_fetch_d = tx_kind_d;
      end
      default: begin
        tx_pins_d  = '0;
        tx_fetch_d = 1'b0;
      end
    endcase
  end

  // Registered pin drivers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pins_q  <= '0;
      tx_fetch_q <= 1'b0;
    end else begin
      tx_pins_q  <= tx_pins_d;
      tx_fetch_q <= tx_fetch_d;
    end
  end

  assign tx_pins      = tx_pins_q;
  assign tx_fetch     = tx_fetch_q;
  assign tx_busy      = (tx_state != TX_IDLE);
  assign bus.tx_ready = tx_ready_c;

  // ---------------------------------------------------------------- RX side

  logic [IO_BITS-1:0] rx_s;

  generate
    if (RX_SYNC == 0) begin : g_no_sync
      assign rx_s = rx_pins;
    end else begin : g_sync
      logic [IO_BITS-1:0] sync_q [RX_SYNC];

      // Input synchroniser chain ahead of frame detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RX_SYNC; i++) begin
            sync_q[i] <= '0;
          end
        end else begin
          sync_q[0] <= rx_pins;
          for (int i = 1; i < RX_SYNC; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign rx_s = sync_q[RX_SYNC-1];
    end
  endgenerate

  rx_state_t             rx_state, rx_state_d;
  logic [BEAT_W-1:0]     rx_beat, rx_beat_d;
  logic [WORD_BITS-1:0]  rx_shift;
  logic [WORD_BITS-1:0]  rx_word;
  logic                  rx_done;
  logic                  rx_load;
  logic                  rx_valid_q, rx_valid_d;
  logic [WORD_BITS-1:0]  rx_data_q;
  logic                  rx_overflow_q, rx_overflow_d;

  // RX state register, beat counter and beat collection slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_beat  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_beat  <= rx_beat_d;
      if (rx_state == RX_DATA) begin
        rx_shift[int'(rx_beat)*IO_BITS +: IO_BITS] <= rx_s;
      end
    end
  end

  // RX next-state: only bit 0 starts a frame; after the last beat the very next cycle may start again.
  always_comb begin
    rx_state_d = rx_state;
    rx_beat_d  = rx_beat;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_s[0]) begin
          rx_state_d = RX_DATA;
        end
        rx_beat_d = '0;
      end
      RX_DATA: begin
        if (rx_beat == LAST_BEAT) begin
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
          rx_beat_d  = '0;
        end else begin
          rx_beat_d = rx_beat + BEAT_W'(1);
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_beat_d  = '0;
      end
    endcase
  end

  // RX outputs: assemble the finished word and decide between loading it and reporting overflow.
  always_comb begin
    rx_word = rx_shift;
    rx_word[int'(rx_beat)*IO_BITS +: IO_BITS] = rx_s;
    rx_load       = rx_done && (!rx_valid_q || bus.rx_ready);
    rx_overflow_d = rx_done && !rx_load;
    rx_valid_d    = rx_valid_q;
    if (rx_load) begin
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Output slot: holds the delivered word until consumed, and the one-cycle overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      rx_valid_q    <= rx_valid_d;
      rx_overflow_q <= rx_overflow_d;
      if (rx_load) begin
        rx_data_q <= rx_word;
      end
    end
  end

  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_overflow = rx_overflow_q;
  assign rx_busy         = (rx_state != RX_IDLE);

endmodule
